excp_ctrl: RTL and testbench

- Sequential exception controller for the multicycle MIPS datapath, upstream of the memory-address mux; its excp_addr output feeds mux input 11 (excpCtrl_output).
- On overflow, invalid opcode or divide-by-zero it:
  - saves EPC;
  - latches the cause;
  - drives the vector byte address to memory and waits for read data;
  - loads the zero-extended handler byte into PC.
- While it runs, it stalls the main control unit.

---
 rtl/excp_ctrl_if.sv | 44 ++++
 rtl/excp_ctrl.sv | 140 ++++++++++++++
 tb/tb_excp_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/excp_ctrl_if.sv
// Exception controller bus.
// Groups every signal exchanged between the multicycle datapath/control unit
// and the exception controller.
//   master : datapath side. Drives the exception flags, PC value and memory
//            read data; receives the stall, vector address, EPC/PC strobes
//            and status.
//   slave  : exception controller side (excp_ctrl).
// Signals:
//   invalid_opcode, overflow, div_by_zero : exception flags from decode/ALU/divider
//   pc_current [31:0] : PC register value (already incremented by 4)
//   mem_data   [31:0] : memory read data; only the low byte is consumed
//   excp_active       : stall for the main control unit, selects mux input 11
//   excp_addr  [31:0] : handler vector byte address
//   epc_write, epc_out[31:0] : EPC write strobe and value
//   cause      [1:0]  : latched cause (00 none, 01 opcode, 10 overflow, 11 div0)
//   pc_load, pc_new[31:0]    : PC write strobe and handler address
//   double_fault      : sticky, exception raised while the controller was busy
interface excp_ctrl_if;
  logic        invalid_opcode;
  logic        overflow;
  logic        div_by_zero;
  logic [31:0] pc_current;
  logic [31:0] mem_data;
  logic        excp_active;
  logic [31:0] excp_addr;
  logic        epc_write;
  logic [31:0] epc_out;
  logic [1:0]  cause;
  logic        pc_load;
  logic [31:0] pc_new;
  logic        double_fault;

  modport master (
    output invalid_opcode, overflow, div_by_zero, pc_current, mem_data,
    input  excp_active, excp_addr, epc_write, epc_out, cause,
           pc_load, pc_new, double_fault
  );

  modport slave (
    input  invalid_opcode, overflow, div_by_zero, pc_current, mem_data,
    output excp_active, excp_addr, epc_write, epc_out, cause,
           pc_load, pc_new, double_fault
  );
endinterface

// File: rtl/excp_ctrl.sv
// Sequential exception controller for the multicycle MIPS datapath.
// On an exception flag in IDLE it saves EPC (PC-4), latches the cause,
// drives the handler vector byte address to memory, waits MEM_LAT cycles for
// read data and loads the zero-extended handler byte into PC. excp_active
// stalls the main control unit for the whole sequence.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : excp_ctrl_if.slave (flags, pc_current, mem_data in;
//             excp_active, excp_addr, epc_write, epc_out, cause, pc_load,
//             pc_new, double_fault out; all outputs registered)
module excp_ctrl #(
  parameter logic [31:0] VEC_OPC = 32'd253,
  parameter logic [31:0] VEC_OVF = 32'd254,
  parameter logic [31:0] VEC_DIV = 32'd255,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  excp_ctrl_if.slave  bus
);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_OVF  = 2'b10;
  localparam logic [1:0] CAUSE_DIV  = 2'b11;
  localparam logic [2:0] LAT        = 3'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, SAVE, ADDR, LOAD} state_t;

  state_t      state;
  logic [2:0]  wait_cnt;
  logic        excp_active;
  logic [31:0] excp_addr;
  logic        epc_write;
  logic [31:0] epc_out;
  logic [1:0]  cause;
  logic        pc_load;
  logic [31:0] pc_new;
  logic        double_fault;

  logic        any_flag;
  logic        unused_mem_hi;

  // Coincident flags resolve opcode > overflow > div0.
  function automatic logic [1:0] pick_cause(input logic opc, input logic ovf,
                                            input logic dz);
    if (opc)      return CAUSE_OPC;
    else if (ovf) return CAUSE_OVF;
    else if (dz)  return CAUSE_DIV;
    else          return CAUSE_NONE;
  endfunction

  function automatic logic [31:0] vector_addr(input logic [1:0] c);
    case (c)
      CAUSE_OPC: return VEC_OPC;
      CAUSE_OVF: return VEC_OVF;
      CAUSE_DIV: return VEC_DIV;
      default:   return 32'd0;
    endcase
  endfunction

  assign any_flag = bus.invalid_opcode | bus.overflow | bus.div_by_zero;

  // Handler vectors are single bytes; the upper read-data bits are discarded.
  assign unused_mem_hi = ^bus.mem_data[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      excp_active  <= 1'b0;
      excp_addr    <= '0;
      epc_write    <= 1'b0;
      epc_out      <= '0;
      cause        <= CAUSE_NONE;
      pc_load      <= 1'b0;
      pc_new       <= '0;
      double_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          excp_active <= 1'b0;
          epc_write   <= 1'b0;
          pc_load     <= 1'b0;
          excp_addr   <= '0;
          if (any_flag) begin
            // Outputs for SAVE are set up on this edge so they are visible
            // during the SAVE cycle itself.
            cause       <= pick_cause(bus.invalid_opcode, bus.overflow,
                                      bus.div_by_zero);
            excp_addr   <= vector_addr(pick_cause(bus.invalid_opcode,
                                                  bus.overflow,
                                                  bus.div_by_zero));
            epc_out     <= bus.pc_current - 32'd4;
            epc_write   <= 1'b1;
            excp_active <= 1'b1;
            state       <= SAVE;
          end
        end
        SAVE: begin
          epc_write <= 1'b0;
          wait_cnt  <= LAT;
          state     <= ADDR;
        end
        ADDR: begin
          // Counter reaching zero marks the cycle the read data is valid.
          if (wait_cnt == 3'd0) begin
            pc_new  <= {24'b0, bus.mem_data[7:0]};
            pc_load <= 1'b1;
            state   <= LOAD;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        LOAD: begin
          pc_load     <= 1'b0;
          excp_active <= 1'b0;
          excp_addr   <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Flags while busy are not queued; they only mark the fault.
      if (state != IDLE && any_flag)
        double_fault <= 1'b1;
    end
  end

  assign bus.excp_active  = excp_active;
  assign bus.excp_addr    = excp_addr;
  assign bus.epc_write    = epc_write;
  assign bus.epc_out      = epc_out;
  assign bus.cause        = cause;
  assign bus.pc_load      = pc_load;
  assign bus.pc_new       = pc_new;
  assign bus.double_fault = double_fault;

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed testbench for excp_ctrl: one DUT at MEM_LAT=1, one at MEM_LAT=3.
module tb_excp_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  excp_ctrl_if b1();
  excp_ctrl_if b3();

  excp_ctrl #(.MEM_LAT(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  excp_ctrl #(.MEM_LAT(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3));

  always #5 clk = ~clk;

  task automatic test_reset();
    b1.invalid_opcode = 0; b1.overflow = 0; b1.div_by_zero = 0;
    b1.pc_current = 32'd0; b1.mem_data = 32'd0;
    b3.invalid_opcode = 0; b3.overflow = 0; b3.div_by_zero = 0;
    b3.pc_current = 32'd0; b3.mem_data = 32'd0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    tests++; if (b1.excp_active !== 1'b0) begin fails++; $display("FAIL rst_active got %b exp 0", b1.excp_active); end
    tests++; if (b1.excp_addr !== 32'd0) begin fails++; $display("FAIL rst_addr got %h exp 0", b1.excp_addr); end
    tests++; if (b1.epc_out !== 32'd0) begin fails++; $display("FAIL rst_epc got %h exp 0", b1.epc_out); end
    tests++; if ({b1.epc_write, b1.pc_load, b1.double_fault, b1.cause} !== 5'd0) begin
      fails++; $display("FAIL rst_ctrl got %b exp 00000", {b1.epc_write, b1.pc_load, b1.double_fault, b1.cause}); end
    tests++; if (b1.pc_new !== 32'd0) begin fails++; $display("FAIL rst_pcnew got %h exp 0", b1.pc_new); end
    reset_n = 1;
    repeat (2) @(negedge clk);
    tests++; if (b1.excp_active !== 1'b0 || b1.excp_addr !== 32'd0) begin
      fails++; $display("FAIL idle_hold got act=%b addr=%h exp 0/0", b1.excp_active, b1.excp_addr); end
  endtask

  // Overflow at default latency: EPC next cycle, pc_load four cycles after flag.
  task automatic test_overflow();
    b1.pc_current = 32'h0000_0108; b1.mem_data = 32'h0000_0040; b1.overflow = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      b1.overflow = 0;
      tests++; if (b1.epc_write !== (c == 1)) begin fails++; $display("FAIL ovf_epcw c=%0d got %b exp %b", c, b1.epc_write, (c == 1)); end
      tests++; if (b1.pc_load !== (c == 4)) begin fails++; $display("FAIL ovf_pcld c=%0d got %b exp %b", c, b1.pc_load, (c == 4)); end
      tests++; if (b1.excp_active !== (c <= 4)) begin fails++; $display("FAIL ovf_act c=%0d got %b exp %b", c, b1.excp_active, (c <= 4)); end
      tests++; if (b1.excp_addr !== ((c <= 4) ? 32'd254 : 32'd0)) begin fails++; $display("FAIL ovf_addr c=%0d got %0d", c, b1.excp_addr); end
      if (c == 1) begin
        tests++; if (b1.epc_out !== 32'h104) begin fails++; $display("FAIL ovf_epc got %h exp 104", b1.epc_out); end
        tests++; if (b1.cause !== 2'b10) begin fails++; $display("FAIL ovf_cause got %b exp 10", b1.cause); end
      end
      if (c == 4) begin
        tests++; if (b1.pc_new !== 32'h40) begin fails++; $display("FAIL ovf_pcnew got %h exp 40", b1.pc_new); end
      end
    end
    tests++; if (b1.cause !== 2'b10 || b1.epc_out !== 32'h104) begin
      fails++; $display("FAIL ovf_retain got cause=%b epc=%h exp 10/104", b1.cause, b1.epc_out); end
    tests++; if (b1.double_fault !== 1'b0) begin fails++; $display("FAIL ovf_df got %b exp 0", b1.double_fault); end
  endtask

  // Coincident opcode and div0: opcode wins, no double fault.
  task automatic test_priority();
    b1.pc_current = 32'h20; b1.mem_data = 32'h0000_0011;
    b1.invalid_opcode = 1; b1.div_by_zero = 1;
    @(negedge clk);
    b1.invalid_opcode = 0; b1.div_by_zero = 0;
    tests++; if (b1.cause !== 2'b01) begin fails++; $display("FAIL pri_cause got %b exp 01", b1.cause); end
    tests++; if (b1.excp_addr !== 32'd253) begin fails++; $display("FAIL pri_addr got %0d exp 253", b1.excp_addr); end
    tests++; if (b1.epc_out !== 32'h1C) begin fails++; $display("FAIL pri_epc got %h exp 1c", b1.epc_out); end
    repeat (3) @(negedge clk);
    tests++; if (b1.pc_load !== 1'b1 || b1.pc_new !== 32'h11) begin
      fails++; $display("FAIL pri_load got ld=%b new=%h exp 1/11", b1.pc_load, b1.pc_new); end
    repeat (2) @(negedge clk);
    tests++; if (b1.double_fault !== 1'b0) begin fails++; $display("FAIL pri_df got %b exp 0", b1.double_fault); end
  endtask

  // Div0 with PC=0: EPC wraps, only the low read byte reaches PC.
  task automatic test_div_wrap();
    b1.pc_current = 32'd0; b1.mem_data = 32'hFFFF_FF9A; b1.div_by_zero = 1;
    @(negedge clk);
    b1.div_by_zero = 0;
    tests++; if (b1.epc_out !== 32'hFFFF_FFFC) begin fails++; $display("FAIL div_epc got %h exp fffffffc", b1.epc_out); end
    tests++; if (b1.excp_addr !== 32'd255 || b1.cause !== 2'b11) begin
      fails++; $display("FAIL div_addr got addr=%0d cause=%b exp 255/11", b1.excp_addr, b1.cause); end
    repeat (3) @(negedge clk);
    tests++; if (b1.pc_load !== 1'b1 || b1.pc_new !== 32'h0000_009A) begin
      fails++; $display("FAIL div_pcnew got ld=%b new=%h exp 1/0000009a", b1.pc_load, b1.pc_new); end
    repeat (2) @(negedge clk);
  endtask

  // Second flag inside the sequence: ignored for sequencing, sets double_fault.
  task automatic test_double_fault();
    int epcw_n;
    int pcld_n;
    epcw_n = 0; pcld_n = 0;
    b1.pc_current = 32'h200; b1.mem_data = 32'h33; b1.overflow = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      b1.overflow = 0; b1.invalid_opcode = 0;
      if (c == 1) begin
        b1.overflow = 1; b1.invalid_opcode = 1; b1.pc_current = 32'h400;
      end
      if (b1.epc_write === 1'b1) epcw_n++;
      if (b1.pc_load === 1'b1) pcld_n++;
    end
    tests++; if (epcw_n != 1) begin fails++; $display("FAIL df_epcw_count got %0d exp 1", epcw_n); end
    tests++; if (pcld_n != 1) begin fails++; $display("FAIL df_pcld_count got %0d exp 1", pcld_n); end
    tests++; if (b1.cause !== 2'b10 || b1.epc_out !== 32'h1FC) begin
      fails++; $display("FAIL df_orig got cause=%b epc=%h exp 10/1fc", b1.cause, b1.epc_out); end
    tests++; if (b1.pc_new !== 32'h33) begin fails++; $display("FAIL df_pcnew got %h exp 33", b1.pc_new); end
    tests++; if (b1.double_fault !== 1'b1 || b1.excp_active !== 1'b0) begin
      fails++; $display("FAIL df_sticky got df=%b act=%b exp 1/0", b1.double_fault, b1.excp_active); end
  endtask

  // Asynchronous reset in ADDR aborts the exception.
  task automatic test_reset_mid();
    int pcld_n;
    pcld_n = 0;
    b1.pc_current = 32'h80; b1.mem_data = 32'h77; b1.overflow = 1;
    @(negedge clk);
    b1.overflow = 0;
    @(negedge clk);
    tests++; if (b1.excp_active !== 1'b1) begin fails++; $display("FAIL rm_pre got %b exp 1", b1.excp_active); end
    #2 reset_n = 0;
    #1;
    tests++; if (b1.excp_active !== 1'b0 || b1.excp_addr !== 32'd0) begin
      fails++; $display("FAIL rm_async got act=%b addr=%h exp 0/0", b1.excp_active, b1.excp_addr); end
    tests++; if (b1.cause !== 2'b00 || b1.double_fault !== 1'b0) begin
      fails++; $display("FAIL rm_status got cause=%b df=%b exp 00/0", b1.cause, b1.double_fault); end
    @(negedge clk);
    reset_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b1.pc_load === 1'b1) pcld_n++;
    end
    tests++; if (pcld_n != 0) begin fails++; $display("FAIL rm_noload got %0d exp 0", pcld_n); end
  endtask

  // MEM_LAT=3: ADDR lasts 4 cycles, pc_load 6 cycles after flag; flag in
  // the first IDLE cycle afterwards starts a clean new sequence.
  task automatic test_lat3();
    int addr_n;
    addr_n = 0;
    b3.pc_current = 32'h1000; b3.mem_data = 32'h55; b3.overflow = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      b3.overflow = 0;
      tests++; if (b3.epc_write !== (c == 1)) begin fails++; $display("FAIL l3_epcw c=%0d got %b exp %b", c, b3.epc_write, (c == 1)); end
      tests++; if (b3.pc_load !== (c == 6)) begin fails++; $display("FAIL l3_pcld c=%0d got %b exp %b", c, b3.pc_load, (c == 6)); end
      tests++; if (b3.excp_addr !== ((c <= 6) ? 32'd254 : 32'd0)) begin fails++; $display("FAIL l3_addr c=%0d got %0d", c, b3.excp_addr); end
      if (b3.excp_active === 1'b1 && b3.epc_write === 1'b0 && b3.pc_load === 1'b0) addr_n++;
      if (c == 6) begin
        tests++; if (b3.pc_new !== 32'h55) begin fails++; $display("FAIL l3_pcnew got %h exp 55", b3.pc_new); end
      end
    end
    tests++; if (addr_n != 4) begin fails++; $display("FAIL l3_addr_len got %0d exp 4", addr_n); end
    b3.div_by_zero = 1; b3.mem_data = 32'h21;
    @(negedge clk);
    b3.div_by_zero = 0;
    tests++; if (b3.epc_write !== 1'b1 || b3.cause !== 2'b11 || b3.excp_addr !== 32'd255) begin
      fails++; $display("FAIL l3_restart got w=%b cause=%b addr=%0d exp 1/11/255", b3.epc_write, b3.cause, b3.excp_addr); end
    tests++; if (b3.double_fault !== 1'b0 || b3.epc_out !== 32'hFFC) begin
      fails++; $display("FAIL l3_restart_st got df=%b epc=%h exp 0/ffc", b3.double_fault, b3.epc_out); end
    repeat (5) @(negedge clk);
    tests++; if (b3.pc_load !== 1'b1 || b3.pc_new !== 32'h21) begin
      fails++; $display("FAIL l3_reload got ld=%b new=%h exp 1/21", b3.pc_load, b3.pc_new); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_priority();
    test_div_wrap();
    test_double_fault();
    test_reset_mid();
    test_lat3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
